// File: rtl/dram_lut_rd_valid_mon_if.sv
// dram_lut_rd_valid_mon_if: sweep control, read strobes and status word of the LUT read monitor
interface dram_lut_rd_valid_mon_if;
  logic        start;
  logic        rd_req;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic [31:0] user_data_out;
  modport master (output start, rd_req, rd_valid, input busy, done, user_data_out);
  modport slave (input start, rd_req, rd_valid, output busy, done, user_data_out);
endinterface

// File: rtl/dram_lut_rd_valid_mon.sv
// dram_lut_rd_valid_mon: counts LUT read requests/returns of one sweep, flags faults, packs a status word
module dram_lut_rd_valid_mon #(
  parameter int LUT_DEPTH = 1024,
  parameter int OUT_MAX   = 255,
  parameter int TIMEOUT   = 4096
) (
  input logic                     user_clk,
  input logic                     user_rst,
  dram_lut_rd_valid_mon_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  state_e          state_q, state_d, es;
  logic [15:0]     req_cnt_q, req_cnt_d, valid_cnt_q, valid_cnt_d, b_req, b_valid;
  logic [7:0]      out_q, out_d, b_out;
  logic [TW-1:0]   tmr_q, tmr_d, b_tmr;
  logic            uf_q, uf_d, ov_q, ov_d, to_q, to_d;
  logic            act, acc, vld, tmo;
  logic [31:0]     dout_q;
  // start acts as a clear in front of normal RUN processing, so same-cycle strobes count after it
  always_comb begin
    es = bus.start ? RUN : state_q;
    b_req = bus.start ? '0 : req_cnt_q;
    b_valid = bus.start ? '0 : valid_cnt_q;
    b_out = bus.start ? '0 : out_q;
    b_tmr = bus.start ? '0 : tmr_q;
    act = es == RUN || es == DRAIN;
    acc = es == RUN && bus.rd_req;
    vld = act && bus.rd_valid;
    req_cnt_d = b_req + 16'(acc);
    valid_cnt_d = vld && b_valid != 16'hFFFF ? b_valid + 16'd1 : b_valid;
    out_d = acc && !vld ? (b_out == 8'(OUT_MAX) ? b_out : b_out + 8'd1) :
            vld && !acc && b_out != 8'd0 ? b_out - 8'd1 : b_out;
    tmr_d = !act || vld || b_out == 8'd0 ? '0 : b_tmr + TW'(1);
    tmo = act && tmr_d == TW'(TIMEOUT);
    uf_d = (uf_q && !bus.start) || (vld && !acc && b_out == 8'd0);
    ov_d = (ov_q && !bus.start) || (es == DRAIN && bus.rd_req) ||
           (acc && !vld && b_out == 8'(OUT_MAX));
    to_d = (to_q && !bus.start) || tmo;
    state_d = tmo ? DONE :
              acc && req_cnt_d == 16'(LUT_DEPTH) ? DRAIN :
              es == DRAIN && b_out == 8'd0 ? DONE : es;
  end
  assign bus.busy = state_q == RUN || state_q == DRAIN;
  assign bus.done = state_q == DONE;
  assign bus.user_data_out = dout_q;
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q <= IDLE;
      req_cnt_q <= '0;
      valid_cnt_q <= '0;
      out_q <= '0;
      tmr_q <= '0;
      uf_q <= 1'b0;
      ov_q <= 1'b0;
      to_q <= 1'b0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      req_cnt_q <= req_cnt_d;
      valid_cnt_q <= valid_cnt_d;
      out_q <= out_d;
      tmr_q <= tmr_d;
      uf_q <= uf_d;
      ov_q <= ov_d;
      to_q <= to_d;
      dout_q <= {bus.done, bus.busy, uf_q, ov_q, to_q, state_q, 1'b0, out_q, valid_cnt_q};
    end
  end
endmodule

// File: tb/tb_dram_lut_rd_valid_mon.sv
// tb_dram_lut_rd_valid_mon: directed sweeps plus random traffic against a cycle-level behavioural model
module tb_dram_lut_rd_valid_mon;
  localparam int LUT_DEPTH = 8;
  localparam int OUT_MAX = 3;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic user_rst;
  int n_cmp = 0;
  int n_bad = 0;
  int m_st, m_req, m_vc, m_out, m_tmr;
  bit m_uf, m_ov, m_to;
  logic [31:0] m_dout;
  dram_lut_rd_valid_mon_if bus();
  dram_lut_rd_valid_mon #(.LUT_DEPTH(LUT_DEPTH), .OUT_MAX(OUT_MAX), .TIMEOUT(TIMEOUT)) dut (
    .user_clk(clk),
    .user_rst(user_rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [31:0] pack();
    return {m_st == 3, m_st == 1 || m_st == 2, m_uf, m_ov, m_to, 2'(m_st), 1'b0, 8'(m_out), 16'(m_vc)};
  endfunction
  task automatic clear_model();
    m_req = 0; m_vc = 0; m_out = 0; m_tmr = 0; m_uf = 0; m_ov = 0; m_to = 0;
  endtask
  // states: 0 idle, 1 run, 2 drain, 3 done
  task automatic model(input logic s, input logic rq, input logic rv, input logic rs);
    int o0;
    bit acc;
    if (rs) begin
      clear_model();
      m_st = 0;
      m_dout = 0;
      return;
    end
    m_dout = pack();
    if (s) begin
      clear_model();
      m_st = 1;
    end
    if (m_st == 1 || m_st == 2) begin
      o0 = m_out;
      acc = m_st == 1 && rq;
      if (m_st == 2 && rq) m_ov = 1;
      if (rv && m_vc < 65535) m_vc++;
      if (acc) m_req++;
      if (acc && !rv) begin
        if (m_out == OUT_MAX) m_ov = 1;
        else m_out++;
      end else if (rv && !acc) begin
        if (m_out == 0) m_uf = 1;
        else m_out--;
      end
      m_tmr = (rv || o0 == 0) ? 0 : m_tmr + 1;
      if (m_tmr == TIMEOUT) begin
        m_to = 1;
        m_st = 3;
      end else if (acc && m_req == LUT_DEPTH) m_st = 2;
      else if (m_st == 2 && o0 == 0) m_st = 3;
    end
  endtask
  task automatic step(input logic s, input logic rq, input logic rv, input logic rs);
    bus.start = s;
    bus.rd_req = rq;
    bus.rd_valid = rv;
    user_rst = rs;
    @(posedge clk);
    model(s, rq, rv, rs);
    #1;
    chk("busy", 32'(bus.busy), 32'(m_st == 1 || m_st == 2));
    chk("done", 32'(bus.done), 32'(m_st == 3));
    chk("dout", bus.user_data_out, m_dout);
    chk("req_cnt", 32'(dut.req_cnt_q), 32'(m_req));
  endtask
  initial begin
    int pq, pv, ps, len;
    m_st = 0;
    clear_model();
    m_dout = 0;
    step(0, 0, 0, 1);
    chk("rst_dout", bus.user_data_out, 32'h0);
    step(0, 0, 0, 1);
    // full sweep, each return two cycles after its request
    step(1, 0, 0, 0);
    for (int i = 1; i <= 14; i++) step(0, i <= 8, i >= 3 && i <= 10, 0);
    chk("t1_dout", bus.user_data_out, 32'h86000008);
    chk("t1_busy", 32'(bus.busy), 32'h0);
    // underflow then a normal sweep
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("t2_uf", 32'(bus.user_data_out[29]), 32'h1);
    chk("t2_out0", 32'(bus.user_data_out[23:16]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("t2_done", 32'(bus.user_data_out[31]), 32'h1);
    chk("t2_vc", 32'(bus.user_data_out[15:0]), 32'd9);
    chk("t2_uf_sticky", 32'(bus.user_data_out[29]), 32'h1);
    // outstanding saturation
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("t3_out", 32'(bus.user_data_out[23:16]), 32'h3);
    chk("t3_ov", 32'(bus.user_data_out[28]), 32'h1);
    chk("t3_req", 32'(dut.req_cnt_q), 32'd4);
    // timeout with two reads outstanding
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
    chk("t4_dout", bus.user_data_out, 32'h8E020000);
    // restart coincident with a request
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("t5_out", 32'(bus.user_data_out[23:16]), 32'h1);
    chk("t5_flags", 32'(bus.user_data_out[29:27]), 32'h0);
    chk("t5_req", 32'(dut.req_cnt_q), 32'd1);
    // reset while draining
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    chk("t5_drain", 32'(bus.user_data_out[26:25]), 32'h1);
    step(0, 0, 0, 0);
    chk("t5_drain_st", 32'(bus.user_data_out[26:25]), 32'h2);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    chk("t5_rst_dout", bus.user_data_out, 32'h0);
    chk("t5_rst_busy", 32'(bus.busy), 32'h0);
    // random segments with varying request/return densities
    for (int seg = 0; seg < 60; seg++) begin
      pq = $urandom_range(0, 100);
      pv = $urandom_range(0, 100);
      ps = $urandom_range(0, 1);
      len = $urandom_range(10, 60);
      for (int i = 0; i < len; i++)
        step((i == 0 && ps == 1) || $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < pq, $urandom_range(0, 99) < pv,
             $urandom_range(0, 299) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
